// File: rtl/load_store_unit.sv
// RV32I data-memory stage: turns load/store controls into a registered bus request,
// stalls the core until ack or timeout, and aligns/extends load data.
module load_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_write_data,
  output logic [WIDTH-1:0] o_read_data,
  output logic             o_stall,
  output logic             o_misaligned,
  output logic             o_bus_err,
  output logic             o_bus_req,
  output logic             o_bus_we,
  output logic [WIDTH-1:0] o_bus_addr,
  output logic [3:0]       o_bus_be,
  output logic [WIDTH-1:0] o_bus_wdata,
  input  logic             i_bus_ack,
  input  logic [WIDTH-1:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [7:0]       r_cnt;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;

  logic             w_access;
  logic             w_f3_ok;
  logic             w_align_ok;
  logic             w_legal;
  logic             w_start;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_lane;
  logic [WIDTH-1:0] w_load;

  assign w_access = i_mem_read | i_mem_write;

  // Legality of the requested access: funct3 must exist for the access kind, address aligned to size
  always_comb begin
    w_f3_ok    = 1'b0;
    w_align_ok = 1'b0;
    case (i_funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = ~i_mem_write;
      default:                w_f3_ok = 1'b0;
    endcase
    case (i_funct3[1:0])
      2'b00:   w_align_ok = 1'b1;
      2'b01:   w_align_ok = ~i_addr[0];
      2'b10:   w_align_ok = (i_addr[1:0] == 2'b00);
      default: w_align_ok = 1'b0;
    endcase
  end

  assign w_legal      = w_access & w_f3_ok & w_align_ok;
  assign w_start      = (r_state == S_IDLE) & w_legal;
  assign o_stall      = w_start | (r_state == S_REQ);
  assign o_misaligned = (r_state == S_IDLE) & w_access & ~w_legal;

  // Store lane encoding; loads always read the full word
  always_comb begin
    w_be    = 4'hF;
    w_wdata = i_write_data;
    if (i_mem_write) begin
      case (i_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << i_addr[1:0];
          w_wdata = {4{i_write_data[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << i_addr[1:0];
          w_wdata = {2{i_write_data[15:0]}};
        end
        default: begin
          w_be    = 4'hF;
          w_wdata = i_write_data;
        end
      endcase
    end else begin
      w_be    = 4'hF;
      w_wdata = i_write_data;
    end
  end

  // Load alignment: shift the addressed lane down, then extend per the latched funct3
  always_comb begin
    w_lane = i_bus_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load = {{(WIDTH-8){w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load = {{(WIDTH-16){w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load = {{(WIDTH-8){1'b0}}, w_lane[7:0]};
      3'b101:  w_load = {{(WIDTH-16){1'b0}}, w_lane[15:0]};
      default: w_load = i_bus_rdata;
    endcase
  end

  // Transaction FSM with registered bus outputs, load result and error pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      o_read_data <= '0;
      o_bus_err   <= 1'b0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_be    <= 4'd0;
      o_bus_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_bus_err <= 1'b0;
          if (w_start) begin
            r_state     <= S_REQ;
            r_cnt       <= 8'd0;
            r_funct3    <= i_funct3;
            r_off       <= i_addr[1:0];
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_mem_write;
            o_bus_addr  <= {i_addr[WIDTH-1:2], 2'b00};
            o_bus_be    <= w_be;
            o_bus_wdata <= w_wdata;
          end
        end
        S_REQ: begin
          // An ack on the final allowed cycle still completes normally
          if (i_bus_ack) begin
            if (!o_bus_we) o_read_data <= w_load;
            o_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            if (!o_bus_we) o_read_data <= '0;
            o_bus_err <= 1'b1;
            o_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          o_bus_err <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          o_bus_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model sets per-cycle
// expectations and one negedge process compares every output against them.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, mem_read, mem_write, bus_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, write_data, bus_rdata;
  logic [31:0] read_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        stall, misaligned, bus_err, bus_req, bus_we;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(reset), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_funct3(funct3), .i_addr(addr), .i_write_data(write_data),
    .o_read_data(read_data), .o_stall(stall), .o_misaligned(misaligned),
    .o_bus_err(bus_err), .o_bus_req(bus_req), .o_bus_we(bus_we),
    .o_bus_addr(bus_addr), .o_bus_be(bus_be), .o_bus_wdata(bus_wdata),
    .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata)
  );

  // Model expectations
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_be;
  logic        e_we, e_req, e_stall, e_mis, e_err, wd_known, chk_en;
  // Bus values observed during REQ, for literal checks
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_be;
  logic        t_we;
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("read_data", read_data, e_rdata);
      check("stall", {31'd0, stall}, {31'd0, e_stall});
      check("misaligned", {31'd0, misaligned}, {31'd0, e_mis});
      check("bus_err", {31'd0, bus_err}, {31'd0, e_err});
      check("bus_req", {31'd0, bus_req}, {31'd0, e_req});
      check("bus_we", {31'd0, bus_we}, {31'd0, e_we});
      check("bus_addr", bus_addr, e_addr);
      check("bus_be", {28'd0, bus_be}, {28'd0, e_be});
      if (wd_known) check("bus_wdata", bus_wdata, e_wdata);
    end
  end

  function automatic logic f_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [1:0] off);
    logic ok;
    if (!(rd || wr)) return 1'b0;
    if (wr) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if ((f3 == 3'd1 || f3 == 3'd5) && off[0]) ok = 1'b0;
    if (f3 == 3'd2 && off != 2'd0) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] f_be(input logic wr, input logic [2:0] f3, input logic [1:0] off);
    if (!wr) return 4'hF;
    if (f3 == 3'd0) return 4'b0001 << off;
    if (f3 == 3'd1) return 4'b0011 << off;
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0) return {4{wd[7:0]}};
    if (f3 == 3'd1) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] v;
    int s;
    v = w >> (8 * off);
    case (f3)
      3'd0: begin s = int'(v & 32'hFF);   if (s > 127)   s = s - 256;   return 32'(s); end
      3'd1: begin s = int'(v & 32'hFFFF); if (s > 32767) s = s - 65536; return 32'(s); end
      3'd4: return v & 32'hFF;
      3'd5: return v & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  // One instruction: ack_at is the REQ cycle index carrying bus_ack, -1 for none
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int ack_at);
    int   k;
    logic legal, done, tmo;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; write_data = wd; bus_rdata = rdat;
    legal = f_legal(rd, wr, f3, a[1:0]);
    e_err = 1'b0; e_mis = ~legal; e_stall = legal;
    if (!legal) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; e_mis = 1'b0; e_stall = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e_req = 1'b1; e_stall = 1'b1; e_we = wr; e_addr = {a[31:2], 2'b00};
    e_be = f_be(wr, f3, a[1:0]);
    if (wr) e_wdata = f_wdata(f3, wd);
    wd_known = wr;
    k = 0; tmo = 1'b0; done = 1'b0;
    bus_ack = (ack_at == 0);
    while (!done) begin
      t_addr = bus_addr; t_be = bus_be; t_wdata = bus_wdata; t_we = bus_we;
      @(posedge clk); #1;
      if (bus_ack) done = 1'b1;
      else if (k == TO - 1) begin done = 1'b1; tmo = 1'b1; end
      else begin k++; bus_ack = (ack_at == k); end
    end
    bus_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    e_req = 1'b0; e_stall = 1'b0; e_err = tmo;
    if (!wr) e_rdata = tmo ? 32'h0 : f_load(f3, a[1:0], rdat);
    @(posedge clk); #1;
    e_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
    funct3 = 3'd0; addr = 32'h0; write_data = 32'h0; bus_rdata = 32'h0;
    e_rdata = 32'h0; e_addr = 32'h0; e_wdata = 32'h0; e_be = 4'h0;
    e_we = 1'b0; e_req = 1'b0; e_stall = 1'b0; e_mis = 1'b0; e_err = 1'b0;
    wd_known = 1'b1; chk_en = 1'b0;
    @(posedge clk); #1; chk_en = 1'b1;
    @(posedge clk); #1; reset = 1'b0;

    access(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'h8765_4321, 0);
    check("lw_data", read_data, 32'h8765_4321);
    check("lw_addr", t_addr, 32'h100);
    check("lw_be", {28'd0, t_be}, 32'hF);

    access(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h8012_3456, 1);
    check("lb_sext", read_data, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h8012_3456, 0);
    check("lbu_zext", read_data, 32'h0000_0080);

    access(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0);
    check("sh_addr", t_addr, 32'h200);
    check("sh_be", {28'd0, t_be}, 32'hC);
    check("sh_wdata", t_wdata, 32'hABCD_ABCD);
    check("sh_we", {31'd0, t_we}, 32'h1);
    check("sh_rd_keep", read_data, 32'h0000_0080);

    access(1'b0, 1'b1, 3'd0, 32'h201, 32'h0000_00EF, 32'h0, 2);
    access(1'b1, 1'b1, 3'd2, 32'h204, 32'hDEAD_BEEF, 32'h0, 1);
    access(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h8001_1234, 0);
    check("lh_sext", read_data, 32'hFFFF_8001);
    access(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'h8001_1234, 2);
    check("lhu_zext", read_data, 32'h0000_8001);

    access(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
    access(1'b1, 1'b0, 3'd3, 32'h000, 32'h0, 32'h0, 0);
    access(1'b0, 1'b1, 3'd4, 32'h000, 32'h0, 32'h0, 0);
    access(1'b1, 1'b0, 3'd1, 32'h301, 32'h0, 32'h0, 0);
    access(1'b0, 1'b1, 3'd2, 32'h202, 32'h0, 32'h0, 0);

    access(1'b1, 1'b0, 3'd1, 32'h300, 32'h0, 32'h1111_2222, -1);
    check("tmo_data", read_data, 32'h0);

    access(1'b1, 1'b0, 3'd2, 32'h010, 32'h0, 32'h1357_9BDF, TO - 1);
    check("late_ack_ok", read_data, 32'h1357_9BDF);

    // Reset in the second REQ cycle of a wait-stated load, then a stray ack
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'd2; addr = 32'h400; bus_rdata = 32'h5555_AAAA; e_stall = 1'b1;
    @(posedge clk); #1;
    e_req = 1'b1; e_addr = 32'h400; e_be = 4'hF; e_we = 1'b0; wd_known = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_read = 1'b0; bus_ack = 1'b1;
    e_req = 1'b0; e_stall = 1'b0; e_addr = 32'h0; e_be = 4'h0; e_wdata = 32'h0;
    e_rdata = 32'h0; wd_known = 1'b1;
    check("rst_req", {31'd0, bus_req}, 32'h0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check("rst_ack_ign", read_data, 32'h0);

    access(1'b1, 1'b0, 3'd0, 32'h001, 32'h0, 32'h0000_7F00, 0);
    check("post_rst_lb", read_data, 32'h0000_007F);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the RV32I core. It sits between the execute datapath and the write-back result multiplexer. It turns load/store controls into a registered request/acknowledge transaction on the data bus, and stalls the core until the access completes. For loads it aligns and sign/zero-extends bus data into `read_data`, which feeds the result multiplexer's memory input.

## Interface
Parameters:
- `WIDTH`, 32: data and address width; only 32 is supported.
- `TIMEOUT`, 255: maximum cycles in REQ without `bus_ack` before the access is aborted. Must be 1..255.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `mem_read`, input, 1: the current instruction is a load.
- `mem_write`, input, 1: the current instruction is a store. Takes priority if asserted together with `mem_read`.
- `funct3`, input, 3: access size and signedness, encoded as in RV32I.
- `addr`, input, WIDTH: byte address from the ALU.
- `write_data`, input, WIDTH: rs2 value for stores.
- `read_data`, output, WIDTH: aligned and extended load result, registered.
- `stall`, output, 1: combinational; holds the PC and register-file write while high.
- `misaligned`, output, 1: one-cycle pulse for a misaligned access or an illegal `funct3`.
- `bus_err`, output, 1: one-cycle pulse when an access times out.
- `bus_req`, output, 1: bus request, registered.
- `bus_we`, output, 1: 1 means write, registered.
- `bus_addr`, output, WIDTH: word-aligned address with bits [1:0] = 0, registered.
- `bus_be`, output, 4: byte enables, registered.
- `bus_wdata`, output, WIDTH: lane-replicated store data, registered.
- `bus_ack`, input, 1: slave completion, sampled on the rising edge while in REQ.
- `bus_rdata`, input, WIDTH: full word returned by the slave, valid when `bus_ack` = 1.

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- IDLE with `mem_read|mem_write`:
  - Legality check. LW/SW require `addr[1:0]` = 0. LH/LHU/SH require `addr[0]` = 0.
  - Legal loads are `funct3` 000, 001, 010, 100, 101. Legal stores are 000, 001, 010. Any other value is illegal.
  - Illegal access: pulse `misaligned` in this cycle, keep `stall` = 0, start no bus access, stay in IDLE.
  - Legal access: assert `stall`, register the bus outputs, latch `funct3` and `addr[1:0]`, and go to REQ.
- Store encoding, where `off` = `addr[1:0]`:
  - SB: `be` = 4'b0001<<off; `wdata` = byte 0 of `write_data` replicated to all 4 lanes.
  - SH: `be` = 4'b0011<<off; `wdata` = halfword 0 replicated to both halves.
  - SW: `be` = 4'b1111.
- Loads: `bus_be` = 4'b1111 and `bus_we` = 0.
- REQ:
  - Hold `bus_req` = 1 and all bus outputs stable; `stall` = 1; the timeout counter increments each cycle.
  - On `bus_ack`: for loads, select the byte or halfword at the latched offset. Sign-extend for LB/LH, zero-extend for LBU/LHU, take the whole word for LW. Register the result into `read_data`. Then go to DONE.
  - If the counter reaches `TIMEOUT` without an ack: `read_data` ← 0 for loads, pulse `bus_err` on entry to DONE, go to DONE.
- DONE: `bus_req` = 0, `stall` = 0, so the instruction retires and write-back uses `read_data`. The next state is always IDLE, and inputs are ignored in this cycle.
- Stores never modify `read_data`. `read_data` otherwise holds its last value.

## Timing
- Reset values: `read_data` = 0, `bus_req` = 0, `bus_we` = 0, `bus_addr` = 0, `bus_be` = 0, `bus_wdata` = 0, `misaligned` = 0, `bus_err` = 0, `stall` = 0, counter = 0.
- `stall` = (IDLE && legal request) || REQ.
- Latency with `bus_ack` on the first REQ cycle: `stall` is high for 2 cycles (IDLE, REQ) and the instruction retires in the 3rd cycle (DONE). Each wait state adds 1 cycle.
- `bus_req` rises on the edge leaving IDLE and falls on the edge after the ack is sampled. It is never asserted for two back-to-back transactions without an intervening DONE and IDLE.
- A late `bus_ack` in DONE or IDLE is ignored.
- Timeout: exactly `TIMEOUT` REQ cycles, then DONE.
- `reset` mid-transaction: on the next edge the FSM is in IDLE, `bus_req` = 0, and all outputs are at their reset values. A pending ack is discarded.

## Test plan
- LW at 0x100, `bus_rdata` = 0x8765_4321, ack on the first REQ cycle: `bus_addr` = 0x100, `bus_be` = 4'hF, `stall` = 1,1,0, and `read_data` = 0x8765_4321 in DONE.
- LB at 0x103 and LBU at 0x103, `bus_rdata` = 0x80xx_xxxx: LB gives `read_data` = 0xFFFF_FF80; LBU gives 0x0000_0080.
- SH at 0x202, `write_data` = 0x1234_ABCD: `bus_addr` = 0x200, `bus_be` = 4'b1100, `bus_wdata` = 0xABCD_ABCD, `bus_we` = 1, and `read_data` is unchanged.
- LW at 0x101: `misaligned` pulses for 1 cycle, `bus_req` stays 0, `stall` = 0.
- LH at 0x300 with no ack and `TIMEOUT` = 4: 4 REQ cycles, then `bus_err` pulses, `read_data` = 0, `stall` drops.
- `reset` asserted in the 2nd REQ cycle of a wait-stated load: next cycle `bus_req` = 0, FSM in IDLE; an ack one cycle later has no effect.
